data_mem_ctrl: RTL



---
 rtl/data_mem_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Data-side memory controller behind the processor's Memory1/Memory2 stages.
//   Serves one load or store at a time from an internal word-addressed RAM.
//   Each access takes LATENCY wait cycles. DataDone is held low while an
//   access is in flight so the pipeline stalls. The block also keeps
//   saturating load/store/stall counters and a sticky error flag.
//
// Ports
//   Clock       in   clock; all state changes on posedge
//   Reset       in   synchronous, active-high; RAM contents are not cleared
//   DataAddr    in   request word address
//   DataOut     in   store data from the processor
//   ReadData    in   load request
//   WriteData   in   store request (when both requests are high, a store wins)
//   DataIn      out  load data; holds until the next load completes
//   DataDone    out  1 = idle or completing, 0 = stall the pipeline
//   ErrFlag     out  sticky: out-of-range address or both requests high
//   RdCount     out  completed loads, saturating
//   WrCount     out  completed stores, saturating
//   StallCount  out  cycles spent with DataDone low, saturating
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter int CNT_BITS  = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 ErrFlag,
    output logic [CNT_BITS-1:0]  RdCount,
    output logic [CNT_BITS-1:0]  WrCount,
    output logic [CNT_BITS-1:0]  StallCount
);

    localparam int                 AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]         LAT     = 4'(LATENCY);
    localparam logic [WORD_SIZE:0] DEPTH_W = (WORD_SIZE+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state_q;
    logic [3:0]           wait_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 wr_q;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic                 accept;
    logic                 req_in_range;
    logic                 perf;
    logic [WORD_SIZE-1:0] p_addr;
    logic [WORD_SIZE-1:0] p_data;
    logic                 p_wr;
    logic                 p_in_range;
    logic [WORD_SIZE-1:0] rdata;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (c == '1) ? c : c + CNT_BITS'(1);
    endfunction

    // Requests are sampled only when no access is in flight. While BUSY the
    // processor holds the same request, so it has to be ignored.
    assign accept       = (state_q != BUSY) && (ReadData || WriteData);
    assign req_in_range = {1'b0, DataAddr} < DEPTH_W;

    // This selects the access performed at the coming edge. With zero latency
    // it is the request being accepted right now. Otherwise it is the latched
    // request finishing its last BUSY cycle.
    always_comb begin
        perf   = 1'b0;
        p_addr = addr_q;
        p_data = wdata_q;
        p_wr   = wr_q;
        if (LATENCY == 0) begin
            perf   = accept;
            p_addr = DataAddr;
            p_data = DataOut;
            p_wr   = WriteData;
        end else begin
            perf = (state_q == BUSY) && (wait_q == 4'd1);
        end
    end

    assign p_in_range = {1'b0, p_addr} < DEPTH_W;
    assign rdata      = p_in_range ? mem[p_addr[AW-1:0]] : '0;

    // The RAM is not reset. A store that completes on a reset edge is dropped.
    always_ff @(posedge Clock) begin
        if (!Reset && perf && p_wr && p_in_range)
            mem[p_addr[AW-1:0]] <= p_data;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            DataDone   <= 1'b1;
            DataIn     <= '0;
            ErrFlag    <= 1'b0;
            RdCount    <= '0;
            WrCount    <= '0;
            StallCount <= '0;
        end else begin
            if (accept) begin
                addr_q  <= DataAddr;
                wdata_q <= DataOut;
                wr_q    <= WriteData;
                if (!req_in_range || (ReadData && WriteData))
                    ErrFlag <= 1'b1;
            end

            case (state_q)
                IDLE, RESP: begin
                    if (accept && LATENCY == 0) begin
                        state_q  <= RESP;
                        DataDone <= 1'b1;
                    end else if (accept) begin
                        state_q  <= BUSY;
                        DataDone <= 1'b0;
                        wait_q   <= LAT;
                    end else begin
                        state_q  <= IDLE;
                        DataDone <= 1'b1;
                    end
                end
                BUSY: begin
                    StallCount <= sat_inc(StallCount);
                    if (wait_q == 4'd1) begin
                        state_q  <= RESP;
                        DataDone <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    DataDone <= 1'b1;
                end
            endcase

            if (perf) begin
                if (p_wr) begin
                    WrCount <= sat_inc(WrCount);
                end else begin
                    RdCount <= sat_inc(RdCount);
                    DataIn  <= rdata;
                end
            end
        end
    end

endmodule
